// File: rtl/cbus_pkg.sv
// Cache-bus request/response types shared by the caches, the arbiter and the AXI converter.
// AXI burst length encodings are stored as beats-1.
package cbus_pkg;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [3:0]  len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

  localparam logic [3:0] AXI_BURST_LEN_1  = 4'd0;
  localparam logic [3:0] AXI_BURST_LEN_2  = 4'd1;
  localparam logic [3:0] AXI_BURST_LEN_4  = 4'd3;
  localparam logic [3:0] AXI_BURST_LEN_8  = 4'd7;
  localparam logic [3:0] AXI_BURST_LEN_16 = 4'd15;

endpackage

// File: rtl/rr_select.sv
// Round-robin pick: first set bit of valid scanning ptr, ptr+1, ... modulo N; combinational.
// No handshake of its own; the caller decides when the pick is taken.
module rr_select #(
  parameter int N     = 2,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     valid,
  input  logic [IDX_W-1:0] ptr,
  output logic             any_valid,
  output logic [IDX_W-1:0] idx
);

  int cand;

  // Scan farthest-first so the candidate closest to ptr is written last and wins.
  always_comb begin
    any_valid = |valid;
    idx       = '0;
    cand      = 0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = int'(ptr) + k;
      if (cand >= N) cand = cand - N;
      if (valid[cand]) idx = IDX_W'(cand);
    end
  end

endmodule

// File: rtl/cbus_arbiter.sv
// Round-robin merge of NUM_INPUTS CBus requesters onto one port; grant 1 cycle after valid, held for the burst.
// Losers see all-zero responses; ready/last from downstream reach the winner combinationally.
module cbus_arbiter
  import cbus_pkg::*;
#(
  parameter int NUM_INPUTS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  ireqs  [NUM_INPUTS],
  output cbus_resp_t oresps [NUM_INPUTS],
  output cbus_req_t  oreq,
  input  cbus_resp_t oresp
);

  localparam int IDX_W = $clog2(NUM_INPUTS);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                  state, state_nxt;
  logic [IDX_W-1:0]        sel, sel_nxt;
  logic [IDX_W-1:0]        ptr, ptr_nxt;
  logic [NUM_INPUTS-1:0]   req_vld;
  logic                    any_vld;
  logic [IDX_W-1:0]        pick;

  always_comb begin
    for (int i = 0; i < NUM_INPUTS; i++) req_vld[i] = ireqs[i].valid;
  end

  rr_select #(
    .N     (NUM_INPUTS),
    .IDX_W (IDX_W)
  ) u_rr_select (
    .valid     (req_vld),
    .ptr       (ptr),
    .any_valid (any_vld),
    .idx       (pick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sel   <= '0;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      sel   <= sel_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    ptr_nxt   = ptr;
    oreq      = '0;
    for (int i = 0; i < NUM_INPUTS; i++) oresps[i] = '0;

    case (state)
      IDLE: begin
        if (any_vld) begin
          state_nxt = BUSY;
          sel_nxt   = pick;
        end
      end
      BUSY: begin
        oreq = ireqs[sel];
        for (int i = 0; i < NUM_INPUTS; i++) begin
          if (IDX_W'(i) == sel) oresps[i] = oresp;
        end
        // Explicit wrap: NUM_INPUTS need not be a power of two.
        if (oresp.ready && oresp.last) begin
          state_nxt = IDLE;
          ptr_nxt   = (sel == IDX_W'(NUM_INPUTS - 1)) ? '0 : sel + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cbus_arbiter.sv
// Bench for cbus_arbiter (3 requesters): directed scenarios plus random traffic,
// every cycle compared against a transaction-level round-robin model.
module tb_cbus_arbiter;
  import cbus_pkg::*;

  localparam int N = 3;

  logic       clk = 1'b0;
  logic       reset;
  cbus_req_t  ireqs  [N];
  cbus_resp_t oresps [N];
  cbus_req_t  oreq;
  cbus_resp_t oresp;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: who owns the bus (-1 = nobody), where the next scan starts,
  // and how many beats of the current grant have completed.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_beats = 0;
  bit done_flag = 1'b0;
  int done_idx  = 0;

  bit rand_mode  = 1'b0;
  bit persist    = 1'b0;
  bit rdy_always = 1'b0;
  int rdy_q[$];
  int exp_q[$];
  int grant_log[$];
  int gap_log[$];
  int idle_run = 0;
  bit prev_vld = 1'b0;

  cbus_arbiter #(.NUM_INPUTS(N)) dut (
    .clk    (clk),
    .reset  (reset),
    .ireqs  (ireqs),
    .oresps (oresps),
    .oreq   (oreq),
    .oresp  (oresp)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic check_outputs();
    cbus_req_t  e_req;
    cbus_resp_t e_resp;
    int         who;
    if (m_owner >= 0) e_req = ireqs[m_owner];
    else              e_req = '0;
    check("oreq", {51'd0, oreq}, {51'd0, e_req});
    for (int i = 0; i < N; i++) begin
      if (m_owner == i) e_resp = oresp;
      else              e_resp = '0;
      check($sformatf("oresps[%0d]", i), {94'd0, oresps[i]}, {94'd0, e_resp});
    end
    if (oreq.valid && !prev_vld) begin
      who = -1;
      for (int j = N - 1; j >= 0; j--)
        if (ireqs[j].valid && ireqs[j] == oreq) who = j;
      grant_log.push_back(who);
      gap_log.push_back(idle_run);
      idle_run = 0;
    end else if (!oreq.valid) begin
      idle_run++;
    end
    prev_vld = oreq.valid;
  endtask

  task automatic model_edge();
    bit found;
    done_flag = 1'b0;
    if (reset) begin
      m_owner = -1;
      m_ptr   = 0;
    end else if (m_owner < 0) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (!found && ireqs[(m_ptr + k) % N].valid) begin
          found   = 1'b1;
          m_owner = (m_ptr + k) % N;
          m_beats = 0;
        end
      end
    end else if (oresp.ready) begin
      if (oresp.last) begin
        done_flag = 1'b1;
        done_idx  = m_owner;
        m_ptr     = (m_owner + 1) % N;
        m_owner   = -1;
      end else begin
        m_beats++;
      end
    end
  endtask

  task automatic new_req(input int i, input int len, input logic [31:0] addr);
    ireqs[i].valid    = 1'b1;
    ireqs[i].is_write = 1'($urandom);
    ireqs[i].size     = 3'd2;
    ireqs[i].addr     = addr;
    ireqs[i].strobe   = 4'($urandom);
    ireqs[i].data     = $urandom;
    ireqs[i].len      = 4'(len);
  endtask

  task automatic drive();
    int r;
    if (done_flag && !persist) ireqs[done_idx].valid = 1'b0;
    if (rand_mode) begin
      for (int i = 0; i < N; i++)
        if (!ireqs[i].valid && $urandom_range(2) == 0)
          new_req(i, $urandom_range(3), $urandom);
      reset = ($urandom_range(79) == 0);
    end
    oresp.data = rand_mode ? $urandom : 32'hDEAD_BEEF;
    if (m_owner >= 0) begin
      if (rdy_q.size() > 0) begin
        r = rdy_q.pop_front();
        oresp.ready = (r != 0);
      end else if (rdy_always) begin
        oresp.ready = 1'b1;
      end else begin
        oresp.ready = ($urandom_range(3) != 0);
      end
      oresp.last = oresp.ready && (m_beats == int'(ireqs[m_owner].len));
    end else begin
      oresp.ready = 1'($urandom);
      oresp.last  = 1'($urandom);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
    drive();
  endtask

  function automatic bit any_req();
    bit a = 1'b0;
    for (int i = 0; i < N; i++) a |= ireqs[i].valid;
    return a;
  endfunction

  task automatic drain(input int max);
    int n = 0;
    while ((m_owner >= 0 || any_req()) && n < max) begin
      cycle();
      n++;
    end
    if (n >= max) check("drain_timeout", 128'd0, 128'd1);
  endtask

  task automatic clear_logs();
    grant_log.delete();
    gap_log.delete();
    idle_run = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  task automatic check_grants(input string tag);
    int g;
    for (int k = 0; k < exp_q.size(); k++) begin
      g = (k < grant_log.size()) ? grant_log[k] : -1;
      check($sformatf("%s_grant%0d", tag, k), 128'(g), 128'(exp_q[k]));
    end
  endtask

  task automatic check_gaps(input string tag, input int n);
    int g;
    for (int k = 1; k < n; k++) begin
      g = (k < gap_log.size()) ? gap_log[k] : -1;
      check($sformatf("%s_gap%0d", tag, k), 128'(g), 128'd1);
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < N; i++) ireqs[i] = '0;
    oresp = '0;
    @(posedge clk);
    #1;

    // Reset held 3 cycles with port 0 requesting; grant one cycle after release.
    clear_logs();
    new_req(0, 0, 32'h0000_0100);
    repeat (3) cycle();
    reset = 1'b0;
    drain(50);
    exp_q = {0};
    check_grants("reset");
    check("reset_latency", 128'(gap_log.size() > 0 ? gap_log[0] : -1), 128'd4);

    // Single read on port 1, completing on its third busy cycle.
    clear_logs();
    new_req(1, 0, 32'h8000_0040);
    rdy_q = {0, 0, 1};
    drain(50);
    exp_q = {1};
    check_grants("single");

    // Contention from reset: 0,1,0,1 with one-cycle bubbles.
    do_reset();
    clear_logs();
    new_req(0, 0, 32'h0000_1000);
    new_req(1, 0, 32'h0000_2000);
    persist = 1'b1;
    rdy_always = 1'b1;
    repeat (8) cycle();
    persist = 1'b0;
    drain(50);
    exp_q = {0, 1, 0, 1};
    check_grants("contend");
    check_gaps("contend", 4);

    // Burst hold: 4-beat burst on port 0 with a stalled beat, port 1 waits.
    do_reset();
    clear_logs();
    rdy_always = 1'b0;
    new_req(0, 3, 32'h0000_3000);
    new_req(1, 0, 32'h0000_4000);
    rdy_q = {1, 0, 1, 1, 1, 1};
    drain(50);
    exp_q = {0, 1};
    check_grants("burst");

    // Reset after beat 2 of 4; port 0 still valid and is regranted.
    do_reset();
    clear_logs();
    rdy_always = 1'b1;
    new_req(0, 3, 32'h0000_5000);
    repeat (3) cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    drain(50);
    exp_q = {0, 0};
    check_grants("midreset");

    // Three-way fairness.
    do_reset();
    clear_logs();
    new_req(0, 0, 32'h0000_6000);
    new_req(1, 0, 32'h0000_7000);
    new_req(2, 0, 32'h0000_8000);
    persist = 1'b1;
    repeat (12) cycle();
    persist = 1'b0;
    drain(50);
    exp_q = {0, 1, 2, 0, 1, 2};
    check_grants("fair");
    check_gaps("fair", 6);

    // Random traffic with random resets and stalls.
    rdy_always = 1'b0;
    rand_mode  = 1'b1;
    repeat (3000) cycle();
    rand_mode = 1'b0;
    reset     = 1'b0;
    drain(1000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
